// File: rtl/rl_drive_select_if.sv
// Request handshake between the drive-control logic and the RL02 drive-select sequencer.
// The requester drives the strobe and drive number. The sequencer returns ready and the error pulse.
interface rl_drive_select_if #(
  parameter int SEL_W = 2
) ();
  logic             req_valid;
  logic [SEL_W-1:0] req_drive;
  logic             req_ready;
  logic             sel_error;

  modport master (
    output req_valid,
    output req_drive,
    input  req_ready,
    input  sel_error
  );

  modport slave (
    input  req_valid,
    input  req_drive,
    output req_ready,
    output sel_error
  );
endinterface

// File: rtl/rl_drive_select.sv
// RL02 drive-select sequencer. It switches the shared select bus, waits for settle and ready,
// and steers the chosen drive's MFM, sector and ready lines into the single read datapath.
module rl_drive_select #(
  parameter int NUM_DRIVES    = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 2000,
  parameter int READY_TIMEOUT = 4000,
  parameter int CNT_W         = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rl_drive_select_if.slave      req,
  input  logic                  write_gate_in,
  input  logic [NUM_DRIVES-1:0] drive_ready_in,
  input  logic [NUM_DRIVES-1:0] sector_in,
  input  logic [NUM_DRIVES-1:0] mfm_in,
  output logic [SEL_W-1:0]      drive_sel,
  output logic [SEL_W-1:0]      cur_drive,
  output logic                  sector_out,
  output logic                  mfm_out,
  output logic                  drive_ready_out,
  output logic                  inhibit_read
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WG,
    SETTLE,
    WAIT_READY
  } stateT;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] READY_LOAD  = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [SEL_W:0]   DRIVE_LIMIT = (SEL_W + 1)'(NUM_DRIVES);

  stateT            stateQ, stateNext;
  logic [CNT_W-1:0] cntQ, cntNext;
  logic [SEL_W-1:0] curQ, curNext;
  logic [SEL_W-1:0] targetQ, targetNext;
  logic             inhibitQ, inhibitNext;
  logic             errQ, errNext;
  logic             sectorQ, mfmQ, readyQ;
  logic             badDrive;

  assign badDrive = ({1'b0, req.req_drive} >= DRIVE_LIMIT);

  // NOTE: every variable gets its default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    stateNext   = stateQ;
    cntNext     = cntQ;
    curNext     = curQ;
    targetNext  = targetQ;
    inhibitNext = inhibitQ;
    errNext     = 1'b0;

    case (stateQ)
      IDLE: begin
        if (req.req_valid) begin
          if (badDrive) begin
            errNext = 1'b1;
          end else if (req.req_drive != curQ) begin
            targetNext = req.req_drive;
            if (write_gate_in) begin
              stateNext = WAIT_WG;
            end else begin
              stateNext   = SETTLE;
              curNext     = req.req_drive;
              cntNext     = SETTLE_LOAD;
              inhibitNext = 1'b1;
            end
          end
        end
      end

      // A write in progress must finish on the old drive before the select moves.
      WAIT_WG: begin
        if (!write_gate_in) begin
          stateNext   = SETTLE;
          curNext     = targetQ;
          cntNext     = SETTLE_LOAD;
          inhibitNext = 1'b1;
        end
      end

      SETTLE: begin
        if (cntQ == '0) begin
          stateNext = WAIT_READY;
          cntNext   = READY_LOAD;
        end else begin
          cntNext = cntQ - 1'b1;
        end
      end

      WAIT_READY: begin
        if (drive_ready_in[curQ]) begin
          stateNext   = IDLE;
          inhibitNext = 1'b0;
        end else if (cntQ == '0) begin
          stateNext   = IDLE;
          inhibitNext = 1'b0;
          errNext     = 1'b1;
        end else begin
          cntNext = cntQ - 1'b1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= SETTLE;
      cntQ     <= SETTLE_LOAD;
      curQ     <= '0;
      targetQ  <= '0;
      inhibitQ <= 1'b1;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateNext;
      cntQ     <= cntNext;
      curQ     <= curNext;
      targetQ  <= targetNext;
      inhibitQ <= inhibitNext;
      errQ     <= errNext;
    end
  end

  // Steering is gated with the next inhibit value, so the outputs drop on the same
  // edge that inhibit rises and carry the new drive's data on the edge it clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sectorQ <= 1'b0;
      mfmQ    <= 1'b0;
      readyQ  <= 1'b0;
    end else begin
      sectorQ <= !inhibitNext && sector_in[curQ];
      mfmQ    <= !inhibitNext && mfm_in[curQ];
      readyQ  <= !inhibitNext && drive_ready_in[curQ];
    end
  end

  assign req.req_ready   = (stateQ == IDLE);
  assign req.sel_error   = errQ;
  assign drive_sel       = curQ;
  assign cur_drive       = curQ;
  assign inhibit_read    = inhibitQ;
  assign sector_out      = sectorQ;
  assign mfm_out         = mfmQ;
  assign drive_ready_out = readyQ;

endmodule

// File: tb/tb_rl_drive_select.sv
// Self-checking bench for rl_drive_select with three drives on the bus.
// Expected timing comes from the settle/ready-wait durations. Steered data comes from the previously driven inputs.
module tb_rl_drive_select;

  localparam int NUM_DRIVES = 3;
  localparam int SEL_W      = 2;
  localparam int SETTLE     = 2000;
  localparam int TIMEOUT    = 4000;
  localparam int CNT_W      = 12;

  logic                  clk;
  logic                  rst_n;
  logic                  write_gate_in;
  logic [NUM_DRIVES-1:0] drive_ready_in;
  logic [NUM_DRIVES-1:0] sector_in;
  logic [NUM_DRIVES-1:0] mfm_in;
  logic [SEL_W-1:0]      drive_sel;
  logic [SEL_W-1:0]      cur_drive;
  logic                  sector_out;
  logic                  mfm_out;
  logic                  drive_ready_out;
  logic                  inhibit_read;

  rl_drive_select_if #(.SEL_W(SEL_W)) req ();

  rl_drive_select #(
    .NUM_DRIVES   (NUM_DRIVES),
    .SEL_W        (SEL_W),
    .SETTLE_CYCLES(SETTLE),
    .READY_TIMEOUT(TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .write_gate_in  (write_gate_in),
    .drive_ready_in (drive_ready_in),
    .sector_in      (sector_in),
    .mfm_in         (mfm_in),
    .drive_sel      (drive_sel),
    .cur_drive      (cur_drive),
    .sector_out     (sector_out),
    .mfm_out        (mfm_out),
    .drive_ready_out(drive_ready_out),
    .inhibit_read   (inhibit_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [SEL_W-1:0]      expCur;
  logic [NUM_DRIVES-1:0] prevSector, prevMfm, prevReady;
  bit                    wgRandom;

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // One clock: capture what the DUT will sample, step past the edge, then compare
  // every output against the expected drive, inhibit, error and ready levels.
  task automatic tick(input bit expInh, input bit expErr, input bit expRdy, input string tag);
    prevSector = sector_in;
    prevMfm    = mfm_in;
    prevReady  = drive_ready_in;
    @(posedge clk);
    #1;
    check(tag, "inhibit_read", 32'(inhibit_read), 32'(expInh));
    check(tag, "sector_out", 32'(sector_out), expInh ? 32'd0 : 32'(prevSector[expCur]));
    check(tag, "mfm_out", 32'(mfm_out), expInh ? 32'd0 : 32'(prevMfm[expCur]));
    check(tag, "drive_ready_out", 32'(drive_ready_out), expInh ? 32'd0 : 32'(prevReady[expCur]));
    check(tag, "sel_error", 32'(req.sel_error), 32'(expErr));
    check(tag, "drive_sel", 32'(drive_sel), 32'(expCur));
    check(tag, "cur_drive", 32'(cur_drive), 32'(expCur));
    check(tag, "req_ready", 32'(req.req_ready), 32'(expRdy));
    sector_in = NUM_DRIVES'($urandom);
    mfm_in    = NUM_DRIVES'($urandom);
    if (wgRandom) write_gate_in = 1'($urandom);
  endtask

  // After reset release: SETTLE clocks with inhibit held, then ready is found at once.
  task automatic resetSettle(input string tag);
    wgRandom = 1'b1;
    for (int i = 1; i <= SETTLE; i++) tick(1'b1, 1'b0, 1'b0, tag);
    wgRandom      = 1'b0;
    write_gate_in = 1'b0;
    tick(1'b0, 1'b0, 1'b1, {tag, "Done"});
  endtask

  // Switch to target: w clocks blocked by write gate, ready low for k clocks of the
  // ready wait, or never ready when timeout is set.
  task automatic doSwitch(input logic [SEL_W-1:0] target, input int w, input int k,
                          input bit timeout, input string tag);
    int n;
    req.req_valid          = 1'b1;
    req.req_drive          = target;
    drive_ready_in[target] = (k == 0) && !timeout;
    if (w > 0) begin
      write_gate_in = 1'b1;
      tick(1'b0, 1'b0, 1'b0, {tag, "WgAccept"});
      req.req_valid = 1'b0;
      for (int i = 1; i < w; i++) tick(1'b0, 1'b0, 1'b0, {tag, "WgHold"});
      write_gate_in = 1'b0;
    end
    expCur = target;
    tick(1'b1, 1'b0, 1'b0, {tag, "Select"});
    req.req_valid = 1'b0;
    wgRandom      = 1'b1;
    n = timeout ? (SETTLE + TIMEOUT) : (SETTLE + k + 1);
    for (int j = 2; j <= n; j++) begin
      tick(1'b1, 1'b0, 1'b0, {tag, "Inhibit"});
      if (!timeout && j == SETTLE + k + 1) drive_ready_in[target] = 1'b1;
    end
    wgRandom      = 1'b0;
    write_gate_in = 1'b0;
    tick(1'b0, timeout, 1'b1, {tag, "Release"});
    if (timeout) tick(1'b0, 1'b0, 1'b1, {tag, "ErrClear"});
  endtask

  task automatic checkResetState(input string tag);
    check(tag, "drive_sel", 32'(drive_sel), 32'd0);
    check(tag, "cur_drive", 32'(cur_drive), 32'd0);
    check(tag, "inhibit_read", 32'(inhibit_read), 32'd1);
    check(tag, "req_ready", 32'(req.req_ready), 32'd0);
    check(tag, "sel_error", 32'(req.sel_error), 32'd0);
    check(tag, "steered", 32'({sector_out, mfm_out, drive_ready_out}), 32'd0);
  endtask

  initial begin
    logic [SEL_W-1:0] tgt;

    rst_n          = 1'b1;
    write_gate_in  = 1'b0;
    drive_ready_in = '1;
    sector_in      = NUM_DRIVES'($urandom);
    mfm_in         = NUM_DRIVES'($urandom);
    req.req_valid  = 1'b0;
    req.req_drive  = '0;
    wgRandom       = 1'b0;
    expCur         = '0;

    // Power-up reset, then the reset settle with drive 0 ready.
    #1 rst_n = 1'b0;
    #1 checkResetState("reset");
    repeat (2) @(posedge clk);
    #1 checkResetState("resetHeld");
    rst_n = 1'b1;
    resetSettle("rstSettle");

    repeat (20) tick(1'b0, 1'b0, 1'b1, "idleDrive0");

    // Switch 0 -> 2 with drive 2 already ready.
    doSwitch(2'd2, 0, 0, 1'b0, "sw0to2");
    repeat (20) tick(1'b0, 1'b0, 1'b1, "idleDrive2");

    // Back to 0, with ready arriving after a random delay.
    doSwitch(2'd0, 0, int'($urandom_range(1, 40)), 1'b0, "sw2to0");

    // Request drive 1 while a write holds the gate for 50 clocks.
    doSwitch(2'd1, 50, int'($urandom_range(0, 20)), 1'b0, "swWg");

    // Out-of-range drive is rejected with a single error pulse.
    req.req_valid = 1'b1;
    req.req_drive = 2'd3;
    tick(1'b0, 1'b1, 1'b1, "reject");
    req.req_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1, "rejectClear");

    // Re-selecting the current drive runs no sequence.
    req.req_valid = 1'b1;
    req.req_drive = expCur;
    repeat (3) tick(1'b0, 1'b0, 1'b1, "sameDrive");
    req.req_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1, "sameDriveIdle");

    // Random switches with random write-gate hold and ready delay.
    for (int r = 0; r < 4; r++) begin
      tgt = SEL_W'((int'(expCur) + int'($urandom_range(1, NUM_DRIVES - 1))) % NUM_DRIVES);
      doSwitch(tgt, int'($urandom_range(0, 4)), int'($urandom_range(0, 30)), 1'b0, "swRand");
      repeat (int'($urandom_range(1, 8))) tick(1'b0, 1'b0, 1'b1, "idleRand");
    end

    // Target never becomes ready: timeout error, inhibit clears, steered ready stays 0.
    tgt = SEL_W'((int'(expCur) + 1) % NUM_DRIVES);
    doSwitch(tgt, 0, 0, 1'b1, "swTimeout");
    repeat (10) tick(1'b0, 1'b0, 1'b1, "idleNotReady");

    // Reset in the middle of a settle, then the reset sequence restarts.
    drive_ready_in = '1;
    tgt = SEL_W'((int'(expCur) + 1) % NUM_DRIVES);
    req.req_valid = 1'b1;
    req.req_drive = tgt;
    expCur        = tgt;
    tick(1'b1, 1'b0, 1'b0, "midSelect");
    req.req_valid = 1'b0;
    repeat (100) tick(1'b1, 1'b0, 1'b0, "midSettle");
    rst_n = 1'b0;
    #1 checkResetState("midReset");
    expCur = '0;
    @(posedge clk);
    #1 checkResetState("midResetHeld");
    rst_n = 1'b1;
    resetSettle("midRstSettle");
    repeat (10) tick(1'b0, 1'b0, 1'b1, "idleFinal");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rl_drive_select.md
# rl_drive_select

Parametrised drive-select sequencer for the RL02 controller. It replaces the grounded sel0/sel1 lines with a selectable drive number for up to NUM_DRIVES drives on a shared bus. It steers the selected drive's synchronised MFM, sector and ready signals into the single read datapath, and enforces select-settle and ready-wait sequencing. While a switch is in progress it holds off the read path through `inhibit_read`.

## Interface
Parameters:
- NUM_DRIVES, 4: number of attached drives, 1..4.
- SEL_W, 2: width of the drive number and the select bus, 1..2.
- SETTLE_CYCLES, 2000: clocks the new select is held before ready is sampled; must be ≥1.
- READY_TIMEOUT, 4000: maximum clocks spent waiting for ready after settle; must be ≥1.
- CNT_W, 12: counter width; must hold max(SETTLE_CYCLES, READY_TIMEOUT)−1.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  select request strobe.
- req_drive  in  SEL_W  requested drive number.
- req_ready  out  1  high only in IDLE; a request is accepted on the edge where req_valid && req_ready.
- write_gate_in  in  1  write gate from drive control; no select change is made while it is high.
- drive_ready_in  in  NUM_DRIVES  per-drive ready, already synchronised.
- sector_in  in  NUM_DRIVES  per-drive sector pulse, already synchronised.
- mfm_in  in  NUM_DRIVES  per-drive MFM data, already synchronised.
- drive_sel  out  SEL_W  select lines, driven to the differential output buffers.
- cur_drive  out  SEL_W  currently selected drive number.
- sector_out, mfm_out, drive_ready_out  out  1 each  steered signals of the current drive.
- inhibit_read  out  1  ORed into the read datapath reset.
- sel_error  out  1  one-cycle pulse when a request is rejected or the ready wait times out.

## Operation
- States: IDLE, WAIT_WG, SETTLE, WAIT_READY.
- Reset values:
  - state = SETTLE with counter = SETTLE_CYCLES−1.
  - drive_sel = 0, cur_drive = 0.
  - inhibit_read = 1.
  - sector_out, mfm_out, drive_ready_out, sel_error = 0.
  - req_ready = 0.
- IDLE, on an accepted request:
  - If req_drive ≥ NUM_DRIVES: pulse sel_error and stay in IDLE; drive_sel is unchanged.
  - If req_drive == cur_drive: accept with no sequence and no inhibit.
  - Otherwise latch the target. If write_gate_in = 0, go to SETTLE; if it is 1, go to WAIT_WG.
- WAIT_WG: wait while write_gate_in = 1. The old drive stays selected and is not inhibited.
- Entering SETTLE (from IDLE or WAIT_WG), on the same edge:
  - drive_sel and cur_drive take the target.
  - counter loads SETTLE_CYCLES−1.
  - inhibit_read goes to 1.
- SETTLE: counter decrements each clock. On the edge where it reads 0, go to WAIT_READY and load counter = READY_TIMEOUT−1.
- WAIT_READY:
  - If drive_ready_in[cur_drive] = 1, go to IDLE and clear inhibit_read.
  - Else if counter = 0, go to IDLE, clear inhibit_read and pulse sel_error. cur_drive keeps the new drive.
  - Else decrement counter.
- Steering:
  - sector_out, mfm_out and drive_ready_out are registered copies of the cur_drive bit of their inputs.
  - All three are forced to 0 while inhibit_read = 1.
- write_gate_in rising during SETTLE or WAIT_READY has no effect on sequencing.
- If rst_n is asserted mid-sequence, everything returns to the reset values immediately; there is no partial select.

## Timing
- Request accepted at edge T with write_gate_in = 0:
  - drive_sel changes and inhibit_read rises at T+1.
  - inhibit_read stays high for SETTLE_CYCLES + k + 1 cycles, where k = clocks ready stayed low in WAIT_READY (k ≤ READY_TIMEOUT−1).
- Request accepted while write_gate_in = 1: drive_sel changes one clock after the edge on which write_gate_in is sampled low.
- Steering latency: 1 clock from input to output.
- sel_error is exactly one cycle wide.
- Rejected request: sel_error is high at T+1.
- req_ready drops at T+1 for any switching request. For same-drive and rejected requests it stays high.

## Test plan
- Reset, drive 0 ready:
  - inhibit_read high for 2001 cycles, then low.
  - req_ready = 1.
  - mfm_out follows mfm_in[0] with 1-clock lag.
- Switch request 0→2, drive 2 ready:
  - drive_sel = 2 at T+1.
  - inhibit_read high for exactly 2001 cycles.
  - sector_out then tracks sector_in[2].
- Request drive 1 while write_gate_in = 1 for 50 cycles:
  - drive_sel stays 0 during those 50 cycles.
  - drive_sel changes to 1 one clock after write_gate_in is seen low.
- Request drive 3 with NUM_DRIVES = 3: sel_error pulses once and drive_sel is unchanged. Same-drive request: no inhibit.
- Switch to a drive whose ready stays low:
  - sel_error fires after 2000+4000 cycles.
  - inhibit_read clears.
  - drive_ready_out = 0.
- Assert rst_n low mid-SETTLE: drive_sel = 0 and inhibit_read = 1 asynchronously, and the reset settle sequence restarts.
